// File: rtl/mbus_pkg.sv
// mbus_pkg: shared mbus state encoding, wbusy edge convention and default widths
package mbus_pkg;
  localparam int MBUS_DQ_W = 16;
  localparam int MBUS_BL = 8;
  localparam int MBUS_AW = 28;
  localparam int MBUS_DW = MBUS_DQ_W * MBUS_BL;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_BUSY, ST_RELEASE} arb_state_t;
  // wbusy fall is taken from two registered samples, so it lands one cycle late
  function automatic logic wbusy_fell(input logic prev, input logic cur);
    return prev & ~cur;
  endfunction
endpackage

// File: rtl/mbus_wr_arbiter_rr_pick.sv
// rr_pick: round-robin priority encoder searching from last+1 upward
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] elig,
  input  logic [2:0]   last,
  output logic         found,
  output logic [2:0]   idx
);
  always_comb begin
    found = |elig;
    idx = '0;
    for (int i = N; i >= 1; i--)
      if (|(elig & (N'(1) << ((int'(last) + i) % N)))) idx = 3'((int'(last) + i) % N);
  end
endmodule

// File: rtl/mbus_wr_arbiter.sv
// mbus_wr_arbiter: round-robin share of one mbus write master between frame-write channels
module mbus_wr_arbiter
  import mbus_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int MEM_DQ_WIDTH = MBUS_DQ_W,
  parameter int BURST_LENGTH = MBUS_BL,
  parameter int CTRL_ADDR_WIDTH = MBUS_AW,
  parameter int ISSUE_TIMEOUT = 255,
  parameter int RELEASE_HOLD = 3
) (
  input  logic                                       i_axi_aclk,
  input  logic                                       i_rstn,
  input  logic [NUM_CH-1:0]                          i_req_wrq,
  input  logic [NUM_CH-1:0]                          i_req_wready,
  input  logic [NUM_CH*CTRL_ADDR_WIDTH-1:0]          i_req_waddr,
  input  logic [NUM_CH*MEM_DQ_WIDTH*BURST_LENGTH-1:0] i_req_wdata,
  output logic [NUM_CH-1:0]                          o_req_wsel,
  output logic [NUM_CH-1:0]                          o_req_wdata_rq,
  output logic [NUM_CH-1:0]                          o_req_wbusy,
  input  logic                                       i_mbus_wdata_rq,
  input  logic                                       i_mbus_wbusy,
  output logic                                       o_mbus_wrq,
  output logic [CTRL_ADDR_WIDTH-1:0]                 o_mbus_waddr,
  output logic [MEM_DQ_WIDTH*BURST_LENGTH-1:0]       o_mbus_wdata,
  output logic                                       o_mbus_wready,
  output logic [2:0]                                 o_grant_idx,
  output logic                                       o_timeout_err
);
  localparam int AW = CTRL_ADDR_WIDTH;
  localparam int DW = MEM_DQ_WIDTH * BURST_LENGTH;
  localparam int TW = $clog2(ISSUE_TIMEOUT + 1);
  localparam int HW = $clog2(RELEASE_HOLD + 2);
  arb_state_t state;
  logic [NUM_CH-1:0] sel;
  logic [2:0] last, pick;
  logic found, wrq, terr, wb_q, wb_qq;
  logic [AW-1:0] waddr;
  logic [TW-1:0] tmr;
  logic [HW-1:0] hold;
  rr_pick #(.N(NUM_CH)) u_pick (
    .elig  (i_req_wrq & i_req_wready),
    .last  (last),
    .found (found),
    .idx   (pick)
  );
  always_ff @(posedge i_axi_aclk or negedge i_rstn)
    if (!i_rstn) begin
      state <= ST_IDLE;
      last <= 3'(NUM_CH - 1);
      sel <= '0;
      wrq <= 1'b0;
      waddr <= '0;
      tmr <= '0;
      hold <= '0;
      terr <= 1'b0;
      wb_q <= 1'b0;
      wb_qq <= 1'b0;
    end else begin
      wb_q <= i_mbus_wbusy;
      wb_qq <= wb_q;
      terr <= 1'b0;
      case (state)
        ST_IDLE:
          if (found) begin
            last <= pick;
            waddr <= i_req_waddr[int'(pick)*AW +: AW];
            sel <= NUM_CH'(1) << pick;
            wrq <= 1'b1;
            tmr <= '0;
            state <= ST_ISSUE;
          end
        ST_ISSUE:
          if (i_mbus_wbusy) begin
            wrq <= 1'b0;
            state <= ST_BUSY;
          end else if (tmr == TW'(ISSUE_TIMEOUT - 1)) begin
            terr <= 1'b1;
            wrq <= 1'b0;
            sel <= '0;
            state <= ST_IDLE;
          end else tmr <= tmr + 1'b1;
        ST_BUSY:
          if (wbusy_fell(wb_qq, wb_q)) begin
            hold <= HW'(RELEASE_HOLD);
            state <= ST_RELEASE;
          end
        ST_RELEASE:
          if (hold <= HW'(1)) begin
            sel <= '0;
            state <= ST_IDLE;
          end else hold <= hold - 1'b1;
      endcase
    end
  // sel is zero whenever idle, so the AND-OR mux also gives 0 out of a grant
  always_comb begin
    o_mbus_wdata = '0;
    for (int k = 0; k < NUM_CH; k++) o_mbus_wdata = o_mbus_wdata | ({DW{sel[k]}} & i_req_wdata[k*DW +: DW]);
  end
  assign o_req_wsel = sel;
  assign o_req_wdata_rq = (state == ST_BUSY && i_mbus_wdata_rq) ? sel : '0;
  assign o_req_wbusy = i_mbus_wbusy ? sel : '0;
  assign o_mbus_wrq = wrq;
  assign o_mbus_waddr = waddr;
  assign o_mbus_wready = |(i_req_wready & sel);
  assign o_grant_idx = last;
  assign o_timeout_err = terr;
endmodule

// File: tb/tb_mbus_wr_arbiter.sv
// tb_mbus_wr_arbiter: scoreboard bench for the mbus write arbiter
module tb_mbus_wr_arbiter;
  localparam int N = 4;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int RH = 3;
  typedef struct {
    logic [N-1:0] sel;
    logic [AW-1:0] addr;
    logic [2:0] idx;
  } exp_t;
  logic clk = 1'b0;
  logic i_rstn = 1'b0;
  logic [N-1:0] i_req_wrq, i_req_wready, o_req_wsel, o_req_wdata_rq, o_req_wbusy;
  logic [N*AW-1:0] i_req_waddr;
  logic [N*DW-1:0] i_req_wdata;
  logic i_mbus_wdata_rq, i_mbus_wbusy, o_mbus_wrq, o_mbus_wready, o_timeout_err;
  logic [AW-1:0] o_mbus_waddr;
  logic [DW-1:0] o_mbus_wdata;
  logic [2:0] o_grant_idx;
  exp_t exp_q[$];
  exp_t e;
  int n_vec = 0, n_err = 0;
  int grants[N] = '{default: 0};
  logic [N-1:0] prev_sel = '0;
  int cur_idx;
  logic [N-1:0] cur_sel;
  int ord[6] = '{0, 1, 3, 0, 1, 3};
  always #5 clk = ~clk;
  mbus_wr_arbiter dut (
    .i_axi_aclk      (clk),
    .i_rstn          (i_rstn),
    .i_req_wrq       (i_req_wrq),
    .i_req_wready    (i_req_wready),
    .i_req_waddr     (i_req_waddr),
    .i_req_wdata     (i_req_wdata),
    .o_req_wsel      (o_req_wsel),
    .o_req_wdata_rq  (o_req_wdata_rq),
    .o_req_wbusy     (o_req_wbusy),
    .i_mbus_wdata_rq (i_mbus_wdata_rq),
    .i_mbus_wbusy    (i_mbus_wbusy),
    .o_mbus_wrq      (o_mbus_wrq),
    .o_mbus_waddr    (o_mbus_waddr),
    .o_mbus_wdata    (o_mbus_wdata),
    .o_mbus_wready   (o_mbus_wready),
    .o_grant_idx     (o_grant_idx),
    .o_timeout_err   (o_timeout_err)
  );
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask
  function automatic logic [AW-1:0] addr(input int k);
    return AW'(32'h100 * (k + 1));
  endfunction
  function automatic logic [DW-1:0] wdat(input int k);
    return {4{32'hD0D0_0000 + 32'(k)}};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push_exp(input int k);
    exp_q.push_back('{N'(1 << k), addr(k), 3'(k)});
  endtask
  task automatic set_cur(input int k);
    cur_idx = k;
    cur_sel = N'(1 << k);
  endtask
  task automatic wait_issue();
    for (int n = 0; n < 20 && !o_mbus_wrq; n++) step();
    check("issue_wait", o_mbus_wrq, 1);
  endtask
  // entered while the arbiter is issuing; busy lasts len cycles from here
  task automatic run_burst(input int len, input bit drop);
    i_mbus_wbusy = 1'b1;
    #1;
    check("busy_route_issue", o_req_wbusy, cur_sel);
    for (int i = 0; i < len - 1; i++) begin
      step();
      if (drop && i == 0) i_req_wrq = '0;
      i_mbus_wdata_rq = i[0];
      #1;
      check("busy_wrq_low", o_mbus_wrq, 0);
      check("busy_sel", o_req_wsel, cur_sel);
      check("drq_route", o_req_wdata_rq, i[0] ? cur_sel : '0);
      check("busy_route", o_req_wbusy, cur_sel);
      check("mbus_wdata", o_mbus_wdata, wdat(cur_idx));
      check("mbus_wready", o_mbus_wready, 1);
    end
    i_mbus_wbusy = 1'b0;
    i_mbus_wdata_rq = 1'b0;
    for (int h = 0; h <= RH + 1; h++) begin
      step();
      if (h == 2) begin
        i_mbus_wdata_rq = 1'b1;
        #1;
        check("drq_release_blocked", o_req_wdata_rq, 0);
        i_mbus_wdata_rq = 1'b0;
      end
      check("release_sel", o_req_wsel, h <= RH ? cur_sel : '0);
    end
  endtask
  always @(negedge clk) begin
    if (i_rstn && prev_sel == '0 && o_req_wsel != '0) begin
      for (int k = 0; k < N; k++) if (o_req_wsel[k]) grants[k]++;
      if (exp_q.size() == 0) check("unexpected_grant", o_req_wsel, 0);
      else begin
        e = exp_q.pop_front();
        check("grant_sel", o_req_wsel, e.sel);
        check("grant_addr", o_mbus_waddr, e.addr);
        check("grant_idx", o_grant_idx, e.idx);
        check("grant_wrq", o_mbus_wrq, 1);
      end
    end
    prev_sel = o_req_wsel;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    int acc, cnt, before2;
    bit got_err;
    i_req_wrq = '0;
    i_req_wready = '0;
    i_mbus_wdata_rq = 1'b1;
    i_mbus_wbusy = 1'b0;
    for (int k = 0; k < N; k++) begin
      i_req_waddr[k*AW +: AW] = addr(k);
      i_req_wdata[k*DW +: DW] = wdat(k);
    end
    repeat (3) step();
    check("rst_wsel", o_req_wsel, 0);
    check("rst_wrq", o_mbus_wrq, 0);
    check("rst_grant_idx", o_grant_idx, N - 1);
    check("rst_timeout", o_timeout_err, 0);
    check("rst_wready", o_mbus_wready, 0);
    check("rst_wdata", o_mbus_wdata, 0);
    check("rst_waddr", o_mbus_waddr, 0);
    check("rst_drq", o_req_wdata_rq, 0);
    i_mbus_wdata_rq = 1'b0;
    i_rstn = 1'b1;
    i_req_wready = '1;
    push_exp(0);
    push_exp(0);
    i_req_wrq = 4'b0001;
    step();
    check("lat_wrq", o_mbus_wrq, 1);
    check("lat_sel", o_req_wsel, 4'b0001);
    check("lat_addr", o_mbus_waddr, 28'h0000100);
    set_cur(0);
    run_burst(16, 0);
    wait_issue();
    run_burst(4, 1);
    i_rstn = 1'b0;
    step();
    i_rstn = 1'b1;
    before2 = grants[2];
    foreach (ord[i]) push_exp(ord[i]);
    i_req_wrq = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      wait_issue();
      set_cur(ord[i]);
      run_burst(4, i == 5);
    end
    check("rr_ch2_never", 32'(grants[2] - before2), 0);
    i_req_wready = '0;
    i_req_wrq = 4'b0010;
    acc = 0;
    repeat (5) begin
      step();
      acc = acc | int'(o_req_wsel);
    end
    check("no_grant_unready", acc, 0);
    i_req_wready = 4'b0010;
    push_exp(1);
    step();
    check("grant_on_ready", o_req_wsel, 4'b0010);
    set_cur(1);
    run_burst(4, 1);
    i_req_wready = '1;
    push_exp(2);
    push_exp(3);
    i_req_wrq = 4'b1100;
    cnt = 0;
    got_err = 1'b0;
    for (int n = 0; n < 300; n++) begin
      step();
      if (o_mbus_wrq) cnt++;
      if (o_timeout_err) begin
        got_err = 1'b1;
        check("timeout_sel", o_req_wsel, 0);
        break;
      end
    end
    check("timeout_seen", got_err, 1);
    check("timeout_len", cnt, 255);
    step();
    check("timeout_pulse_once", o_timeout_err, 0);
    check("timeout_next_ch", o_req_wsel, 4'b1000);
    set_cur(3);
    run_burst(3, 1);
    push_exp(2);
    i_req_wrq = 4'b0100;
    wait_issue();
    set_cur(2);
    run_burst(6, 1);
    push_exp(1);
    i_req_wrq = 4'b0010;
    wait_issue();
    i_mbus_wbusy = 1'b1;
    step();
    step();
    i_mbus_wdata_rq = 1'b1;
    #1;
    check("pre_rst_drq", o_req_wdata_rq, 4'b0010);
    i_rstn = 1'b0;
    #1;
    check("async_rst_wsel", o_req_wsel, 0);
    check("async_rst_wrq", o_mbus_wrq, 0);
    check("async_rst_drq", o_req_wdata_rq, 0);
    check("async_rst_wbusy", o_req_wbusy, 0);
    check("async_rst_grant_idx", o_grant_idx, N - 1);
    i_mbus_wbusy = 1'b0;
    i_mbus_wdata_rq = 1'b0;
    i_req_wrq = '1;
    step();
    push_exp(0);
    i_rstn = 1'b1;
    wait_issue();
    set_cur(0);
    run_burst(4, 1);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
